// File: rtl/idma_desc64_addr_queue_pkg.sv
// idma_desc64_addr_queue_pkg: shared types and sizing helpers for the desc64 address queue
package idma_desc64_addr_queue_pkg;
  localparam int ADDR_WIDTH = 64;
  localparam int DESC_ALIGN = 5;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/idma_desc64_addr_queue_if.sv
// idma_desc64_addr_queue_if: upstream/downstream handshakes and status of the address queue
interface idma_desc64_addr_queue_if
  import idma_desc64_addr_queue_pkg::*;
#(
  parameter int Depth     = 4,
  parameter int AddrWidth = ADDR_WIDTH
);
  logic [AddrWidth-1:0]          in_addr_i;
  logic                          in_valid_i;
  logic                          in_ready_o;
  logic [AddrWidth-1:0]          out_addr_o;
  logic                          out_valid_o;
  logic                          out_ready_i;
  logic [level_width(Depth)-1:0] level_o;
  logic                          empty_o;
  logic                          full_o;
  logic                          misalign_o;
  logic [7:0]                    misalign_cnt_o;
  modport slave (
    input  in_addr_i, in_valid_i, out_ready_i,
    output in_ready_o, out_addr_o, out_valid_o, level_o, empty_o, full_o, misalign_o, misalign_cnt_o
  );
  modport master (
    output in_addr_i, in_valid_i, out_ready_i,
    input  in_ready_o, out_addr_o, out_valid_o, level_o, empty_o, full_o, misalign_o, misalign_cnt_o
  );
endinterface

// File: rtl/idma_desc64_addr_queue.sv
// idma_desc64_addr_queue: in-order descriptor address FIFO that drops misaligned addresses
module idma_desc64_addr_queue
  import idma_desc64_addr_queue_pkg::*;
#(
  parameter int Depth     = 4,
  parameter int AddrWidth = ADDR_WIDTH,
  parameter int DescAlign = DESC_ALIGN
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  idma_desc64_addr_queue_if.slave q
);
  localparam int LW = level_width(Depth);
  localparam int PW = $clog2(Depth);
  logic [AddrWidth-1:0] r_mem [Depth];
  logic [PW-1:0]        r_rd_ptr, r_wr_ptr;
  logic [LW-1:0]        r_level;
  logic                 r_misalign;
  logic [7:0]           r_misalign_cnt;
  logic                 w_push, w_pop, w_bad, w_store, w_take;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(Depth - 1)) ? '0 : p + PW'(1);
  endfunction
  assign q.full_o         = r_level == LW'(Depth);
  assign q.empty_o        = r_level == '0;
  assign q.in_ready_o     = !q.full_o;
  assign q.out_valid_o    = !q.empty_o;
  assign q.out_addr_o     = r_mem[r_rd_ptr];
  assign q.level_o        = r_level;
  assign q.misalign_o     = r_misalign;
  assign q.misalign_cnt_o = r_misalign_cnt;
  assign w_push  = q.in_valid_i && q.in_ready_o;
  assign w_pop   = q.out_valid_o && q.out_ready_i;
  assign w_bad   = |q.in_addr_i[DescAlign-1:0];
  // flush swallows both handshakes of its cycle
  assign w_store = w_push && !w_bad && !flush_i;
  assign w_take  = w_pop && !flush_i;
  always_ff @(posedge clk_i)
    for (int i = 0; i < Depth; i++)
      if (w_store && r_wr_ptr == PW'(i)) r_mem[i] <= q.in_addr_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_ptr       <= '0;
      r_wr_ptr       <= '0;
      r_level        <= '0;
      r_misalign     <= 1'b0;
      r_misalign_cnt <= '0;
    end else begin
      r_misalign <= w_push && w_bad;
      if (w_push && w_bad && r_misalign_cnt != 8'hff) r_misalign_cnt <= r_misalign_cnt + 8'd1;
      if (flush_i) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_level  <= '0;
      end else begin
        if (w_store) r_wr_ptr <= nxt(r_wr_ptr);
        if (w_take) r_rd_ptr <= nxt(r_rd_ptr);
        r_level <= r_level + LW'(w_store) - LW'(w_take);
      end
    end
  end
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i) !(w_pop && r_level == '0));
  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) !(w_push && r_level == LW'(Depth)));
  a_level_max: assert property (@(posedge clk_i) disable iff (rst_i) r_level <= LW'(Depth));
  a_head_stable: assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
    q.out_valid_o && !q.out_ready_i |=> $stable(q.out_addr_o));
endmodule

// File: tb/tb_idma_desc64_addr_queue.sv
// tb_idma_desc64_addr_queue: directed and random scoreboard bench for the descriptor address queue
module tb_idma_desc64_addr_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic go_rand = 1'b0;
  logic last_push;
  logic seen_3000 = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  int exp_cnt = 0;
  logic [63:0] sb[$];
  always #5 clk = ~clk;
  idma_desc64_addr_queue_if #(.Depth(4), .AddrWidth(64)) qi ();
  idma_desc64_addr_queue #(.Depth(4), .AddrWidth(64), .DescAlign(5)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .q(qi)
  );
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic step(input logic v, input logic [63:0] a, input logic r, input logic f);
    logic push, pop, bad;
    qi.in_valid_i = v; qi.in_addr_i = a; qi.out_ready_i = r; flush = f;
    push = v && qi.in_ready_o;
    pop = qi.out_valid_o && r;
    bad = a[4:0] != 5'd0;
    check("in_ready", 64'(qi.in_ready_o), 64'(sb.size() < 4));
    check("out_valid", 64'(qi.out_valid_o), 64'(sb.size() != 0));
    check("empty", 64'(qi.empty_o), 64'(sb.size() == 0));
    check("full", 64'(qi.full_o), 64'(sb.size() == 4));
    if (pop && sb.size() != 0) begin
      check("out_addr", qi.out_addr_o, sb[0]);
      void'(sb.pop_front());
    end
    if (f) sb.delete();
    else if (push && !bad) sb.push_back(a);
    if (push && bad && exp_cnt != 255) exp_cnt++;
    last_push = push;
    @(negedge clk);
    check("level", 64'(qi.level_o), 64'(sb.size()));
    check("misalign_cnt", 64'(qi.misalign_cnt_o), 64'(exp_cnt));
    check("misalign", 64'(qi.misalign_o), 64'(push && bad));
  endtask
  always @(negedge clk) if (qi.out_valid_o && qi.out_addr_o == 64'h3000) seen_3000 <= 1'b1;
  for (genvar g = 0; g < 3; g++) begin : gr
    localparam int D = (g == 0) ? 2 : (g == 1) ? 3 : 7;
    logic rflush;
    logic done;
    logic [63:0] rsb[$];
    idma_desc64_addr_queue_if #(.Depth(D), .AddrWidth(64)) rq ();
    idma_desc64_addr_queue #(.Depth(D), .AddrWidth(64), .DescAlign(5)) rdut (
      .clk_i(clk), .rst_i(rst), .flush_i(rflush), .q(rq)
    );
    initial begin
      logic v, r, f, pend, push, pop;
      logic [63:0] a;
      rq.in_valid_i = 1'b0; rq.in_addr_i = '0; rq.out_ready_i = 1'b0; rflush = 1'b0;
      done = 1'b0; pend = 1'b0; v = 1'b0; a = '0;
      wait (go_rand);
      @(negedge clk);
      for (int c = 0; c < 800; c++) begin
        check($sformatf("rnd%0d_level", D), 64'(rq.level_o), 64'(rsb.size()));
        if (!pend) begin
          v = 1'($urandom_range(0, 1));
          a = {$urandom, $urandom};
          a[4:0] = ($urandom_range(0, 7) == 0) ? 5'h08 : 5'h00;
        end
        r = 1'($urandom_range(0, 1));
        f = $urandom_range(0, 63) == 0;
        rq.in_valid_i = v; rq.in_addr_i = a; rq.out_ready_i = r; rflush = f;
        push = v && rq.in_ready_o;
        pop = rq.out_valid_o && r;
        if (pop) begin
          if (rsb.size() == 0) check($sformatf("rnd%0d_pop_empty", D), 64'd1, 64'd0);
          else begin
            check($sformatf("rnd%0d_out_addr", D), rq.out_addr_o, rsb[0]);
            void'(rsb.pop_front());
          end
        end
        if (f) rsb.delete();
        else if (push && a[4:0] == 5'd0) rsb.push_back(a);
        pend = v && !push;
        @(negedge clk);
      end
      rq.in_valid_i = 1'b0; rflush = 1'b0; rq.out_ready_i = 1'b1;
      for (int c = 0; c < D + 2; c++) begin
        if (rq.out_valid_o) begin
          if (rsb.size() == 0) check($sformatf("rnd%0d_extra", D), 64'd1, 64'd0);
          else begin
            check($sformatf("rnd%0d_drain_addr", D), rq.out_addr_o, rsb[0]);
            void'(rsb.pop_front());
          end
        end
        @(negedge clk);
      end
      check($sformatf("rnd%0d_lost", D), 64'(rsb.size()), 64'd0);
      check($sformatf("rnd%0d_final_level", D), 64'(rq.level_o), 64'd0);
      done = 1'b1;
    end
  end
  initial begin
    logic pend;
    logic v;
    logic [63:0] a;
    qi.in_valid_i = 1'b0; qi.in_addr_i = '0; qi.out_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", 64'(qi.in_ready_o), 64'd1);
    check("rst_out_valid", 64'(qi.out_valid_o), 64'd0);
    check("rst_empty", 64'(qi.empty_o), 64'd1);
    check("rst_full", 64'(qi.full_o), 64'd0);
    check("rst_level", 64'(qi.level_o), 64'd0);
    check("rst_cnt", 64'(qi.misalign_cnt_o), 64'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 64'h1000 + 64'(i) * 64'h20, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    check("fill_full", 64'(qi.full_o), 64'd1);
    check("fill_in_ready", 64'(qi.in_ready_o), 64'd0);
    check("fill_level", 64'(qi.level_o), 64'd4);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("drain_empty", 64'(qi.empty_o), 64'd1);
    step(1'b1, 64'h2000, 1'b0, 1'b0);
    step(1'b1, 64'h2020, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 64'h2040 + 64'(i) * 64'h20, 1'b1, 1'b0);
    check("simul_level", 64'(qi.level_o), 64'd2);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 64'h1004, 1'b0, 1'b0);
    check("mis_pulse", 64'(qi.misalign_o), 64'd1);
    check("mis_cnt1", 64'(qi.misalign_cnt_o), 64'd1);
    check("mis_level", 64'(qi.level_o), 64'd0);
    step(1'b0, '0, 1'b0, 1'b0);
    check("mis_pulse_end", 64'(qi.misalign_o), 64'd0);
    for (int i = 0; i < 300; i++) step(1'b1, 64'h1004 + 64'(i) * 64'h40, 1'b0, 1'b0);
    check("mis_sat", 64'(qi.misalign_cnt_o), 64'd255);
    for (int i = 0; i < 3; i++) step(1'b1, 64'h5000 + 64'(i) * 64'h20, 1'b0, 1'b0);
    step(1'b1, 64'h3000, 1'b1, 1'b1);
    check("flush_level", 64'(qi.level_o), 64'd0);
    check("flush_empty", 64'(qi.empty_o), 64'd1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("flush_no_3000", 64'(seen_3000), 64'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 64'h6000 + 64'(i) * 64'h20, 1'b0, 1'b0);
    qi.in_valid_i = 1'b0; qi.out_ready_i = 1'b0; flush = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    exp_cnt = 0;
    check("mid_rst_out_valid", 64'(qi.out_valid_o), 64'd0);
    check("mid_rst_level", 64'(qi.level_o), 64'd0);
    check("mid_rst_cnt", 64'(qi.misalign_cnt_o), 64'd0);
    step(1'b1, 64'h4000, 1'b0, 1'b0);
    check("post_rst_head", qi.out_addr_o, 64'h4000);
    step(1'b0, '0, 1'b1, 1'b0);
    go_rand = 1'b1;
    pend = 1'b0; v = 1'b0; a = '0;
    for (int c = 0; c < 800; c++) begin
      if (!pend) begin
        v = 1'($urandom_range(0, 1));
        a = {$urandom, $urandom};
        a[4:0] = ($urandom_range(0, 7) == 0) ? 5'h10 : 5'h00;
      end
      step(v, a, 1'($urandom_range(0, 1)), $urandom_range(0, 63) == 0);
      pend = v && !last_push;
    end
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("rnd4_lost", 64'(sb.size()), 64'd0);
    for (int i = 0; i < 5000 && !(gr[0].done && gr[1].done && gr[2].done); i++) @(negedge clk);
    check("rnd_done", 64'(gr[0].done && gr[1].done && gr[2].done), 64'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
